// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Types and constants shared by the fetch front end.
//   XLEN         : address / instruction width
//   NOP_INSTR    : canonical NOP (addi x0,x0,0) shown to decode on bubbles
//   fetch_pair_t : {pc, instr} pair carried from fetch to decode
//   RESET_PAIR   : value the decode-facing head register takes on reset
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pair_t;

  localparam fetch_pair_t RESET_PAIR = '{pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry synchronous FIFO of fetch_pair_t with a registered head.
//   The head register is loaded with whatever will sit at the front after
//   this cycle's push/pop, so the decode-facing outputs come straight from a
//   flop. When the FIFO drains or is cleared, the head register keeps its
//   last value.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data (accepted if not full, or full and popping)
//   push_data   : pair to write
//   pop         : consume head (ignored when empty)
//   clear       : drop all entries next cycle; wins over push/pop
//   full, empty : occupancy flags
//   count       : number of valid entries (clog2(DEPTH)+1 bits)
//   head        : registered front entry (meaningful only when !empty)
// ---------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_pair_t      push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_pair_t      head
);

  fetch_pair_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_pair_t      r_head;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_nxt;
  fetch_pair_t      w_head_nxt;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign count    = r_count;
  assign head     = r_head;

  assign w_pop    = pop & ~empty;
  // At full a simultaneous pop frees the slot being written.
  assign w_push   = push & (~full | w_pop);
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  // Front entry after this cycle's operations.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (r_count > CNT_W'(1))
        w_head_nxt = r_mem[w_rd_nxt];
      else if (w_push)
        w_head_nxt = push_data;
    end else if (empty && w_push) begin
      w_head_nxt = push_data;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (!rst && !clear && w_push)
      r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= RESET_PAIR;
    end else if (clear) begin
      // Head register deliberately holds its value across a clear.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_head  <= w_head_nxt;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   Fetch stage sitting right after the PC register. Issues an instruction
//   memory read at pc_in whenever the downstream skid FIFO is guaranteed to
//   have room for the answer, pairs each 1-cycle-latency response with the PC
//   it was issued for, and presents the pairs to decode through fetch_fifo.
//   pc_hold tells the PC register to stay put unless a fetch was issued;
//   during a flush it is released so the PC can load the branch target.
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   pc_in                 : current PC
//   flush                 : branch/jump taken; discard all fetched work
//   imem_req / imem_addr  : read request / address (= pc_in)
//   imem_rdata/imem_rvalid: read response, one cycle after imem_req
//   pc_hold               : 1 = PC must not advance this cycle
//   id_valid / id_ready   : decode handshake
//   id_pc / id_instr      : head pair toward decode
// Configuration
//   IF_ID_BUBBLE_NOP_EN : when defined, id_pc/id_instr show 0/NOP whenever
//                         id_valid=0; otherwise they hold the last head.
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int XLEN  = cpu_pkg::XLEN,  // must match cpu_pkg::XLEN
  parameter int DEPTH = 2               // power of two, >= 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_rvalid,
  output logic            pc_hold,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic            r_inflight;
  logic            r_kill;
  logic            r_rst_d;
  logic [XLEN-1:0] r_pend_pc;

  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occ;
  fetch_pair_t      w_head;
  fetch_pair_t      w_push_pair;

  // Occupancy the FIFO will have once the outstanding response lands,
  // net of this cycle's pop. Issue only if that still leaves a free slot.
  assign w_pop   = ~w_empty & id_ready;
  assign w_occ   = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
  assign w_issue = ~rst & ~flush & (w_occ < (CNT_W+1)'(DEPTH));

  // A response is kept only if it belongs to a live request.
  assign w_push      = imem_rvalid & r_inflight & ~r_kill & ~flush & ~rst;
  assign w_push_pair = '{pc: r_pend_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_pair),
    .pop       (w_pop),
    .clear     (flush),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  always_ff @(posedge clk) begin
    r_rst_d <= rst;
    if (rst) begin
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      if (w_issue) begin
        r_pend_pc  <= pc_in;
        r_inflight <= 1'b1;
      end else if (imem_rvalid) begin
        r_inflight <= 1'b0;
      end
      // A response arriving now is consumed (or dropped by flush) here, so
      // kill is only armed when the doomed response is still to come.
      if (imem_rvalid && r_inflight)
        r_kill <= 1'b0;
      else if (flush && r_inflight)
        r_kill <= 1'b1;
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = pc_in;
  // Released during flush so the PC register loads the target.
  assign pc_hold   = rst | (~flush & ~w_issue);
  assign id_valid  = ~w_empty;

`ifdef IF_ID_BUBBLE_NOP_EN
  assign id_pc    = id_valid ? w_head.pc    : '0;
  assign id_instr = id_valid ? w_head.instr : NOP_INSTR;
`else
  assign id_pc    = w_head.pc;
  assign id_instr = w_head.instr;
`endif

  // A response with nothing outstanding is a memory-side protocol error,
  // except right after reset where a reply to a pre-reset request is
  // expected and silently dropped.
  always @(posedge clk) begin
    if (!rst && !r_rst_d) begin
      assert (!(imem_rvalid && !r_inflight))
        else $error("if_id_stage: imem_rvalid with no request in flight");
      assert (!(w_push && w_full && !w_pop))
        else $error("if_id_stage: push into full fifo");
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        pc_hold;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] flush_tgt;
  logic [31:0] last_a;
  logic [63:0] sb[$];
  logic [63:0] last_pop_exp;

  always #10 clk = ~clk;

  if_id_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .pc_hold     (pc_hold),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Scoreboard: expected pair queued when a fetch is issued, compared when
  // decode pops it. Flush and reset discard everything not yet popped.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb.delete();
    end else begin
      if (id_valid === 1'b1 && id_ready === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop unexpected pair pc=%h instr=%h", id_pc, id_instr);
        end else begin
          last_pop_exp = sb.pop_front();
          if ({id_pc, id_instr} !== last_pop_exp) begin
            n_err++;
            $display("FAIL sb_pair got pc=%h instr=%h exp pc=%h instr=%h",
                     id_pc, id_instr, last_pop_exp[63:32], last_pop_exp[31:0]);
          end
        end
      end
      if (flush === 1'b1) sb.delete();
      if (imem_req === 1'b1) sb.push_back({imem_addr, instr_of(imem_addr)});
    end
  end

  // One clock: PC register and 1-cycle memory model advance on the edge.
  task automatic tick();
    logic adv, v;
    logic [31:0] a;
    #1;
    adv = !pc_hold;
    v   = imem_req;
    a   = imem_addr;
    @(posedge clk); #1;
    if (rst)        pc_in = '0;
    else if (flush) pc_in = flush_tgt;
    else if (adv)   pc_in = pc_in + 32'd4;
    imem_rvalid = v;
    imem_rdata  = instr_of(a);
    last_a      = a;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_ready = 1'b1;
    #2;
    n_vec++;
    if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin
      n_err++; $display("FAIL reset_req req=%b hold=%b exp 0/1", imem_req, pc_hold);
    end
    tick(); #2;
    n_vec++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP) begin
      n_err++; $display("FAIL reset_out valid=%b pc=%h instr=%h exp 0/0/%h", id_valid, id_pc, id_instr, NOP);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      n_vec++;
      if (imem_req !== 1'b1 || pc_hold !== 1'b0 || imem_addr !== 32'(4*c)) begin
        n_err++; $display("FAIL stream_issue c=%0d req=%b hold=%b addr=%h exp 1/0/%h", c, imem_req, pc_hold, imem_addr, 32'(4*c));
      end
      n_vec++;
      if (id_valid !== (c >= 2)) begin
        n_err++; $display("FAIL stream_valid c=%0d got %b exp %b", c, id_valid, (c >= 2));
      end
      if (c == 2) begin
        n_vec++;
        if (id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin
          n_err++; $display("FAIL stream_first got pc=%h instr=%h exp 0/%h", id_pc, id_instr, instr_of(32'h0));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_vec++;
      if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin
        n_err++; $display("FAIL bp_stall k=%0d req=%b hold=%b exp 0/1", k, imem_req, pc_hold);
      end
      n_vec++;
      if (sb.size() == 0 || id_valid !== 1'b1 || {id_pc, id_instr} !== sb[0]) begin
        n_err++; $display("FAIL bp_head k=%0d valid=%b pc=%h instr=%h sb=%0d", k, id_valid, id_pc, id_instr, sb.size());
      end
      tick();
    end
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_flush_inflight();
    bit found = 0;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (imem_rvalid === 1'b1 && last_a == 32'h20) begin found = 1; break; end
      tick();
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL fl_reach response for 0x20 not seen within 20 cycles");
    end
    flush = 1'b1; flush_tgt = 32'h100;
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || pc_hold !== 1'b0) begin
      n_err++; $display("FAIL fl_cycle req=%b hold=%b exp 0/0", imem_req, pc_hold);
    end
    tick();
    flush = 1'b0;
    #2;
    n_vec++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL fl_after valid=%b req=%b addr=%h exp 0/1/100", id_valid, imem_req, imem_addr);
    end
    found = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      if (id_valid === 1'b1) begin found = 1; break; end
    end
    n_vec++;
    if (!found || id_pc !== 32'h100) begin
      n_err++; $display("FAIL fl_target found=%0d pc=%h exp 100", found, id_pc);
    end
  endtask

  task automatic test_flush_pop_resp();
    bit found = 0;
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (id_valid === 1'b1 && imem_rvalid === 1'b1) begin found = 1; break; end
      tick();
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL fpr_reach no cycle with pop and response within 10 cycles");
    end
    flush = 1'b1; flush_tgt = 32'h200;
    tick();
    flush = 1'b0;
    #2;
    n_vec++;
    if (id_valid !== 1'b0) begin
      n_err++; $display("FAIL fpr_empty valid=%b exp 0", id_valid);
    end
    n_vec++;
`ifdef IF_ID_BUBBLE_NOP_EN
    if (id_pc !== 32'h0 || id_instr !== NOP) begin
      n_err++; $display("FAIL fpr_bubble got pc=%h instr=%h exp 0/%h", id_pc, id_instr, NOP);
    end
`else
    if ({id_pc, id_instr} !== last_pop_exp) begin
      n_err++; $display("FAIL fpr_bubble got pc=%h instr=%h exp %h/%h", id_pc, id_instr, last_pop_exp[63:32], last_pop_exp[31:0]);
    end
`endif
    found = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      if (id_valid === 1'b1) begin found = 1; break; end
    end
    n_vec++;
    if (!found || id_pc !== 32'h200) begin
      n_err++; $display("FAIL fpr_target found=%0d pc=%h exp 200", found, id_pc);
    end
  endtask

  task automatic test_bubble();
    logic [63:0] exp_head;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    id_ready = 1'b0;
    #2;
    exp_head = (sb.size() != 0) ? sb[0] : 64'h0;
    n_vec++;
    if (id_valid !== 1'b1 || {id_pc, id_instr} !== exp_head) begin
      n_err++; $display("FAIL bub_pre valid=%b pc=%h instr=%h", id_valid, id_pc, id_instr);
    end
    flush = 1'b1; flush_tgt = 32'h300;
    tick();
    flush = 1'b0;
    #2;
    n_vec++;
`ifdef IF_ID_BUBBLE_NOP_EN
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP) begin
      n_err++; $display("FAIL bub_out valid=%b pc=%h instr=%h exp 0/0/%h", id_valid, id_pc, id_instr, NOP);
    end
`else
    if (id_valid !== 1'b0 || {id_pc, id_instr} !== exp_head) begin
      n_err++; $display("FAIL bub_out valid=%b pc=%h instr=%h exp 0/%h/%h", id_valid, id_pc, id_instr, exp_head[63:32], exp_head[31:0]);
    end
`endif
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    rst = 1'b1;
    #2;
    n_vec++;
    if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin
      n_err++; $display("FAIL rmo_rst req=%b hold=%b exp 0/1", imem_req, pc_hold);
    end
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1;  // stray response after reset
    #2;
    n_vec++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0) begin
      n_err++; $display("FAIL rmo_out valid=%b pc=%h instr=%h exp 0/0/%h", id_valid, id_pc, id_instr, NOP);
    end
    tick(); #2;
    n_vec++;
    if (id_valid !== 1'b0) begin
      n_err++; $display("FAIL rmo_stray valid=%b exp 0", id_valid);
    end
    tick(); #2;
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== instr_of(32'h0)) begin
      n_err++; $display("FAIL rmo_resume valid=%b pc=%h instr=%h exp 1/0/%h", id_valid, id_pc, id_instr, instr_of(32'h0));
    end
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b1; pc_in = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; flush_tgt = '0; last_a = '0;
    last_pop_exp = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_inflight();
    test_flush_pop_resp();
    test_bubble();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
